// File: rtl/sub_seq_pkg.sv
// sub_seq_pkg: shared state type and chunk-count helper for the sequential subtractor
package sub_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;
  function automatic int chunks(input int m, input int n);
    return m / n;
  endfunction
endpackage

// File: rtl/sub_seq_sub_n.sv
// sub_n: one N-bit chunk of A - B - bin, done as a + ~b + ~bin with borrow = ~carry
module sub_n #(
  parameter int N = 4
) (
  output logic [N-1:0] d,
  output logic         bout,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin
);
  logic co;
  assign {co, d} = {1'b0, a} + {1'b0, ~b} + {{N{1'b0}}, ~bin};
  assign bout = ~co;
endmodule

// File: rtl/sub_seq.sv
// sub_seq: M-bit subtractor processing N bits per clock, LSB chunk first, registered borrow
module sub_seq
  import sub_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] DIFF,
  output logic         BOUT,
  output logic         OVF
);
  localparam int K  = chunks(M, N);
  localparam int IW = K > 1 ? $clog2(K) : 1;
  if (M % N != 0) begin : g_bad_width
    $error("sub_seq: M must be a multiple of N");
  end
  sub_state_t    state;
  logic [M-1:0]  a_r, b_r;
  logic [IW-1:0] idx;
  logic          borrow, bo;
  logic [N-1:0]  d;
  sub_n #(.N(N)) u_sub (
    .d   (d),
    .bout(bo),
    .a   (a_r[idx*N +: N]),
    .b   (b_r[idx*N +: N]),
    .bin (borrow)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      DIFF   <= '0;
      BOUT   <= 1'b0;
      OVF    <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= start ? RUN : IDLE;
          busy  <= start;
          if (start) begin
            a_r    <= A;
            b_r    <= B;
            idx    <= '0;
            borrow <= 1'b0;
            DIFF   <= '0;
          end
        end
        RUN: begin
          DIFF[idx*N +: N] <= d;
          borrow           <= bo;
          if (idx == IW'(K - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            BOUT  <= bo;
            OVF   <= (a_r[M-1] != b_r[M-1]) && (d[N-1] != a_r[M-1]);
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sub_seq.sv
// tb_sub_seq: randomized and directed checks of sub_seq against an arithmetic reference model
module tb_sub_seq;
  logic       clk = 1'b0;
  logic       reset, start;
  logic [7:0] A, B;
  logic       busy0, done0, bout0, ovf0;
  logic       busy1, done1, bout1, ovf1;
  logic       busy2, done2, bout2, ovf2;
  logic [7:0] diff0, diff1;
  logic [3:0] diff2;
  int         n_chk = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  sub_seq #(.N(4), .M(8)) u0 (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy0), .done(done0), .DIFF(diff0), .BOUT(bout0), .OVF(ovf0)
  );
  sub_seq #(.N(2), .M(8)) u1 (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy1), .done(done1), .DIFF(diff1), .BOUT(bout1), .OVF(ovf1)
  );
  sub_seq #(.N(4), .M(4)) u2 (
    .clk(clk), .reset(reset), .start(start), .A(A[3:0]), .B(B[3:0]),
    .busy(busy2), .done(done2), .DIFF(diff2), .BOUT(bout2), .OVF(ovf2)
  );
  function automatic void model(input int m, input int a, input int b,
                                output int d, output bit bo, output bit ov);
    int full, sa, sb, sd;
    full = 1 << m;
    d    = (a - b + full) % full;
    bo   = a < b;
    sa   = a >= full / 2 ? a - full : a;
    sb   = b >= full / 2 ? b - full : b;
    sd   = sa - sb;
    ov   = sd >= full / 2 || sd < -(full / 2);
  endfunction
  task automatic op(input logic [7:0] a, input logic [7:0] b);
    int  e8, e4, lat0, lat1, lat2;
    bit  eb8, eo8, eb4, eo4;
    model(8, int'(a), int'(b), e8, eb8, eo8);
    model(4, int'(a[3:0]), int'(b[3:0]), e4, eb4, eo4);
    lat0 = 0; lat1 = 0; lat2 = 0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = 8'($urandom); B = 8'($urandom);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (done0 && lat0 == 0) lat0 = c;
      if (done1 && lat1 == 0) lat1 = c;
      if (done2 && lat2 == 0) lat2 = c;
      n_chk++;
      if ({busy0, busy1, busy2} !== {c < 2, c < 4, 1'b0}) begin
        n_fail++;
        $display("FAIL busy %h-%h c=%0d: got %b want %b", a, b, c, {busy0, busy1, busy2},
                 {c < 2, c < 4, 1'b0});
      end
    end
    n_chk++;
    if ({lat0[3:0], diff0, bout0, ovf0} !== {4'd2, 8'(e8), eb8, eo8}) begin
      n_fail++;
      $display("FAIL n4m8 %h-%h: got lat=%0d diff=%h b=%b v=%b want lat=2 diff=%h b=%b v=%b",
               a, b, lat0, diff0, bout0, ovf0, 8'(e8), eb8, eo8);
    end
    n_chk++;
    if ({lat1[3:0], diff1, bout1, ovf1} !== {4'd4, 8'(e8), eb8, eo8}) begin
      n_fail++;
      $display("FAIL n2m8 %h-%h: got lat=%0d diff=%h b=%b v=%b want lat=4 diff=%h b=%b v=%b",
               a, b, lat1, diff1, bout1, ovf1, 8'(e8), eb8, eo8);
    end
    n_chk++;
    if ({lat2[3:0], diff2, bout2, ovf2} !== {4'd1, 4'(e4), eb4, eo4}) begin
      n_fail++;
      $display("FAIL n4m4 %h-%h: got lat=%0d diff=%h b=%b v=%b want lat=1 diff=%h b=%b v=%b",
               a[3:0], b[3:0], lat2, diff2, bout2, ovf2, 4'(e4), eb4, eo4);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1; start = 1'b0; A = 8'hA5; B = 8'h5A;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy0, done0, diff0, bout0, ovf0, busy1, done1, diff1, busy2, done2, diff2} !== '0) begin
      n_fail++;
      $display("FAIL reset: got %b %b %h %b %b / %b %b %h / %b %b %h want all zero",
               busy0, done0, diff0, bout0, ovf0, busy1, done1, diff1, busy2, done2, diff2);
    end
    reset = 1'b0;
  endtask
  task automatic test_directed;
    op(8'h5A, 8'hC3);
    op(8'h10, 8'h01);
    op(8'h80, 8'h01);
    op(8'h00, 8'hFF);
    op(8'h7F, 8'h7F);
    op(8'h7F, 8'h80);
    op(8'hFF, 8'hFF);
  endtask
  task automatic test_reset_mid_run;
    @(negedge clk);
    A = 8'h5A; B = 8'hC3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy0, diff0[3:0]} !== {1'b1, 4'h7}) begin
      n_fail++;
      $display("FAIL mid_run_partial: got busy=%b lo=%h want busy=1 lo=7", busy0, diff0[3:0]);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++;
    if ({busy0, done0, diff0, bout0, ovf0} !== 12'h0) begin
      n_fail++;
      $display("FAIL mid_run_reset: got busy=%b done=%b diff=%h b=%b v=%b want zeros",
               busy0, done0, diff0, bout0, ovf0);
    end
    repeat (6) @(negedge clk);
    op(8'h33, 8'h11);
  endtask
  task automatic test_back_to_back(input logic [7:0] a1, input logic [7:0] b1,
                                   input logic [7:0] a2, input logic [7:0] b2);
    int e1, e2;
    bit bo1, ov1, bo2, ov2;
    model(8, int'(a1), int'(b1), e1, bo1, ov1);
    model(8, int'(a2), int'(b2), e2, bo2, ov2);
    @(negedge clk);
    A = a1; B = b1; start = 1'b1;
    @(negedge clk);
    A = 8'($urandom); B = 8'($urandom);
    n_chk++;
    if ({busy0, done0} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_run1: got busy=%b done=%b want 1 0", busy0, done0);
    end
    @(negedge clk);
    A = a2; B = b2;
    @(negedge clk);
    n_chk++;
    if ({busy0, done0, diff0, bout0, ovf0} !== {2'b01, 8'(e1), bo1, ov1}) begin
      n_fail++;
      $display("FAIL b2b_first %h-%h: got busy=%b done=%b diff=%h b=%b v=%b want 0 1 %h %b %b",
               a1, b1, busy0, done0, diff0, bout0, ovf0, 8'(e1), bo1, ov1);
    end
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if ({busy0, done0} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_run2a: got busy=%b done=%b want 1 0", busy0, done0);
    end
    @(negedge clk);
    n_chk++;
    if ({busy0, done0} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_run2b: got busy=%b done=%b want 1 0", busy0, done0);
    end
    @(negedge clk);
    n_chk++;
    if ({busy0, done0, diff0, bout0, ovf0} !== {2'b01, 8'(e2), bo2, ov2}) begin
      n_fail++;
      $display("FAIL b2b_second %h-%h: got busy=%b done=%b diff=%h b=%b v=%b want 0 1 %h %b %b",
               a2, b2, busy0, done0, diff0, bout0, ovf0, 8'(e2), bo2, ov2);
    end
    repeat (8) @(negedge clk);
  endtask
  task automatic test_small_exhaustive;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        op({4'($urandom), 4'(i)}, {4'($urandom), 4'(j)});
  endtask
  task automatic test_random;
    for (int k = 0; k < 200; k++) op(8'($urandom), 8'($urandom));
  endtask
  initial begin
    test_reset;
    test_directed;
    test_reset_mid_run;
    test_back_to_back(8'h5A, 8'hC3, 8'h10, 8'h01);
    for (int k = 0; k < 4; k++)
      test_back_to_back(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    test_small_exhaustive;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
